// File: rtl/mag_cmp_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
package mag_cmp_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result encoding, one-hot: bit 0 = LT, bit 1 = EQ, bit 2 = GT.
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_LT   = 3'b001;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_GT   = 3'b100;

  // Elaboration-time legality of a WIDTH/DIGIT pair: WIDTH % DIGIT == 0.
  function automatic bit width_digit_ok(input int width, input int digit);
    return (digit > 0) && (width >= 2) && (width % digit == 0);
  endfunction

  // Digit index width: clog2 of the step count, never below one bit.
  function automatic int idx_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/mag_cmp_digit.sv
// Combinational DIGIT-bit compare cell; exactly one of lt/eq/gt is high.
module mag_cmp_digit
  import mag_cmp_pkg::*;
#(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  // Unsigned compare of one digit pair.
  always_comb begin
    // NOTE: every output gets a default first so no branch can leave one
    // unassigned, which would otherwise infer a latch.
    lt = 1'b0;
    eq = 1'b0;
    gt = 1'b0;
    if (x < y)      lt = 1'b1;
    else if (x > y) gt = 1'b1;
    else            eq = 1'b1;
  end

endmodule

// File: rtl/mag_comparator_seq.sv
// Sequential MSB-first magnitude comparator, DIGIT bits per cycle with
// early exit on the first differing digit; unsigned or two's complement.
module mag_comparator_seq
  import mag_cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic             a_gt_b
);

  localparam int N     = WIDTH / DIGIT;
  localparam int IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

  generate
    if (!width_digit_ok(WIDTH, DIGIT)) begin : g_param_check
      $error("mag_comparator_seq: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [IDX_W-1:0] idx;
  logic [2:0]       result;

  logic [WIDTH-1:0] msb_flip;
  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic             d_lt;
  logic             d_eq;
  logic             d_gt;

  // Inverting both MSBs maps two's complement order onto unsigned order.
  assign msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};

  // Route the digit under the scan index into the single compare cell.
  assign dig_a = op_a[int'(idx)*DIGIT +: DIGIT];
  assign dig_b = op_b[int'(idx)*DIGIT +: DIGIT];

  mag_cmp_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .x  (dig_a),
    .y  (dig_b),
    .lt (d_lt),
    .eq (d_eq),
    .gt (d_gt)
  );

  // Controller: accept, scan MSB digit first, pulse done, back to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= RES_NONE;
      idx    <= IDX_TOP;
      op_a   <= '0;
      op_b   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a   <= a ^ msb_flip;
            op_b   <= b ^ msb_flip;
            result <= RES_NONE;
            idx    <= IDX_TOP;
            busy   <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (d_lt) begin
            result <= RES_LT;
            done   <= 1'b1;
            state  <= DONE;
          end else if (d_gt) begin
            result <= RES_GT;
            done   <= 1'b1;
            state  <= DONE;
          end else if (d_eq && (idx == '0)) begin
            result <= RES_EQ;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          idx   <= IDX_TOP;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign a_lt_b = result[0];
  assign a_eq_b = result[1];
  assign a_gt_b = result[2];

endmodule

// File: tb/tb_mag_comparator_seq.sv
// Self-checking bench: 8-bit/2-bit-digit and 16-bit single-step instances
// against an integer reference model.
module tb_mag_comparator_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int errors = 0;
  int checks = 0;

  // 8-bit, DIGIT=2 instance
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        sm8 = 1'b0;
  logic        busy8, done8, lt8, eq8, gt8;

  // 16-bit, DIGIT=16 instance
  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        sm16 = 1'b0;
  logic        busy16, done16, lt16, eq16, gt16;

  mag_comparator_seq #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .signed_mode(sm8), .busy(busy8), .done(done8),
    .a_lt_b(lt8), .a_eq_b(eq8), .a_gt_b(gt8)
  );

  mag_comparator_seq #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
    .signed_mode(sm16), .busy(busy16), .done(done16),
    .a_lt_b(lt16), .a_eq_b(eq16), .a_gt_b(gt16)
  );

  // Reference: integer compare plus position of the first differing digit.
  // r = {gt, eq, lt}; k = 1-based digit position from MSB, or N if equal.
  function automatic void model(input int w, input int d, input logic [15:0] a,
                                input logic [15:0] b, input logic sm,
                                output int k, output logic [2:0] r);
    int va, vb;
    logic [15:0] x;
    va = int'(a);
    vb = int'(b);
    if (sm && a[w-1]) va = va - (1 << w);
    if (sm && b[w-1]) vb = vb - (1 << w);
    if (va < vb)      r = 3'b001;
    else if (va > vb) r = 3'b100;
    else              r = 3'b010;
    x = a ^ b;
    k = w / d;
    for (int p = w - 1; p >= 0; p--) begin
      if (x[p]) begin
        k = (w - 1 - p) / d + 1;
        break;
      end
    end
  endfunction

  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                         output int e0);
    @(negedge clk);
    a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    e0 = edge_cnt;
    // Inputs changing after acceptance must not matter.
    a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~sm;
  endtask

  task automatic wait_done8(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done8) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic launch16(input logic [15:0] a, input logic [15:0] b, input logic sm,
                          output int e0);
    @(negedge clk);
    a16 = a; b16 = b; sm16 = sm; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    e0 = edge_cnt;
    a16 = 16'($urandom); b16 = 16'($urandom); sm16 = ~sm;
  endtask

  task automatic wait_done16(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done16) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if ({busy8, done8, gt8, eq8, lt8} !== 5'b0) begin errors++;
      $display("FAIL reset8: got %b expected 00000", {busy8, done8, gt8, eq8, lt8}); end
    checks++; if ({busy16, done16, gt16, eq16, lt16} !== 5'b0) begin errors++;
      $display("FAIL reset16: got %b expected 00000", {busy16, done16, gt16, eq16, lt16}); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_equal();
    int e0; logic ok;
    launch8(8'hA5, 8'hA5, 1'b0, e0);
    checks++; if (busy8 !== 1'b1) begin errors++;
      $display("FAIL equal_busy_rise: got %b expected 1", busy8); end
    wait_done8(ok);
    checks++; if (!ok || (edge_cnt - e0) != 4) begin errors++;
      $display("FAIL equal_latency: got %0d expected 4 (ok=%b)", edge_cnt - e0, ok); end
    checks++; if ({busy8, gt8, eq8, lt8} !== 4'b1010) begin errors++;
      $display("FAIL equal_flags: got %b expected 1010", {busy8, gt8, eq8, lt8}); end
    @(posedge clk); #1;
    checks++; if ({busy8, done8, gt8, eq8, lt8} !== 5'b00010) begin errors++;
      $display("FAIL equal_after: got %b expected 00010", {busy8, done8, gt8, eq8, lt8}); end
  endtask

  // Directed single operation on the 8-bit instance, checked against the model.
  task automatic run_directed8(input string name, input logic [7:0] a,
                               input logic [7:0] b, input logic sm);
    int e0, k; logic ok; logic [2:0] r;
    model(8, 2, {8'h0, a}, {8'h0, b}, sm, k, r);
    launch8(a, b, sm, e0);
    wait_done8(ok);
    checks++; if (!ok || (edge_cnt - e0) != k || {gt8, eq8, lt8} !== r) begin errors++;
      $display("FAIL %s: got lat=%0d flags=%b expected lat=%0d flags=%b", name,
               edge_cnt - e0, {gt8, eq8, lt8}, k, r); end
    @(posedge clk); #1;
    checks++; if ({busy8, done8} !== 2'b00) begin errors++;
      $display("FAIL %s_done_fall: got %b expected 00", name, {busy8, done8}); end
  endtask

  task automatic test_early_stop();
    run_directed8("early_unsigned", 8'h80, 8'h7F, 1'b0);
    run_directed8("early_signed", 8'h80, 8'h7F, 1'b1);
  endtask

  task automatic test_last_digit();
    run_directed8("last_unsigned", 8'h12, 8'h13, 1'b0);
    run_directed8("last_signed", 8'hFF, 8'hFE, 1'b1);
  endtask

  task automatic test_start_while_busy();
    int e0; logic ok;
    launch8(8'h00, 8'h01, 1'b0, e0);
    @(posedge clk); #1;                      // E1
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;   // request during SCAN
    @(posedge clk); #1;                      // E2
    start8 = 1'b0;
    wait_done8(ok);
    checks++; if (!ok || (edge_cnt - e0) != 4 || {gt8, eq8, lt8} !== 3'b001) begin errors++;
      $display("FAIL busy_ignore: got lat=%0d flags=%b expected lat=4 flags=001",
               edge_cnt - e0, {gt8, eq8, lt8}); end
    // Start during the DONE cycle must be dropped.
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'h11; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({busy8, done8, gt8, eq8, lt8} !== 5'b00001) begin errors++;
        $display("FAIL hold_flags_%0d: got %b expected 00001", i,
                 {busy8, done8, gt8, eq8, lt8}); end
      @(posedge clk); #1;
    end
    // Next accepted start clears the flags.
    launch8(8'hC0, 8'h40, 1'b0, e0);
    checks++; if ({busy8, gt8, eq8, lt8} !== 4'b1000) begin errors++;
      $display("FAIL clear_on_accept: got %b expected 1000", {busy8, gt8, eq8, lt8}); end
    wait_done8(ok);
    checks++; if (!ok || (edge_cnt - e0) != 1 || {gt8, eq8, lt8} !== 3'b100) begin errors++;
      $display("FAIL after_clear: got lat=%0d flags=%b expected lat=1 flags=100",
               edge_cnt - e0, {gt8, eq8, lt8}); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int e0a, e0b, k; logic ok; logic [2:0] r;
    model(8, 2, 16'h0030, 16'h0010, 1'b0, k, r);
    launch8(8'h30, 8'h10, 1'b0, e0a);
    wait_done8(ok);
    @(posedge clk); #1;
    launch8(8'h01, 8'h01, 1'b0, e0b);
    checks++; if (!ok || (e0b - e0a) != k + 2) begin errors++;
      $display("FAIL back_to_back_interval: got %0d expected %0d", e0b - e0a, k + 2); end
    wait_done8(ok);
    checks++; if (!ok || {gt8, eq8, lt8} !== 3'b010) begin errors++;
      $display("FAIL back_to_back_second: got %b expected 010", {gt8, eq8, lt8}); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_scan();
    int e0; logic seen;
    launch8(8'h00, 8'h00, 1'b0, e0);
    @(posedge clk); #1;                      // index now 2
    rst_n = 1'b0;
    #1;
    checks++; if ({busy8, done8, gt8, eq8, lt8} !== 5'b0) begin errors++;
      $display("FAIL reset_mid: got %b expected 00000", {busy8, done8, gt8, eq8, lt8}); end
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; seen |= done8; end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; seen |= done8 | busy8; end
    checks++; if (seen !== 1'b0) begin errors++;
      $display("FAIL reset_no_done: got %b expected 0", seen); end
    run_directed8("after_reset", 8'h5A, 8'h5B, 1'b0);
  endtask

  task automatic test_single_step();
    int e0, k; logic ok; logic [2:0] r;
    launch16(16'h8000, 16'h0001, 1'b1, e0);
    wait_done16(ok);
    checks++; if (!ok || (edge_cnt - e0) != 1 || {gt16, eq16, lt16} !== 3'b001) begin errors++;
      $display("FAIL single_step: got lat=%0d flags=%b expected lat=1 flags=001",
               edge_cnt - e0, {gt16, eq16, lt16}); end
    @(posedge clk); #1;
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb; logic rs;
      ra = 16'($urandom);
      rb = (i % 7 == 0) ? ra : 16'($urandom);
      rs = i[0];
      model(16, 16, ra, rb, rs, k, r);
      launch16(ra, rb, rs, e0);
      wait_done16(ok);
      checks++; if (!ok || (edge_cnt - e0) != k || {gt16, eq16, lt16} !== r) begin errors++;
        $display("FAIL rand16 a=%h b=%h s=%b: got lat=%0d flags=%b expected lat=%0d flags=%b",
                 ra, rb, rs, edge_cnt - e0, {gt16, eq16, lt16}, k, r); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random8();
    int e0, k; logic ok; logic [2:0] r;
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ra, rb; logic rs;
      ra = 8'($urandom);
      rb = (i % 5 == 0) ? (ra ^ 8'(1 << $urandom_range(7, 0))) : 8'($urandom);
      rs = i[0];
      model(8, 2, {8'h0, ra}, {8'h0, rb}, rs, k, r);
      launch8(ra, rb, rs, e0);
      wait_done8(ok);
      checks++; if (!ok || (edge_cnt - e0) != k || {gt8, eq8, lt8} !== r) begin errors++;
        $display("FAIL rand8 a=%h b=%h s=%b: got lat=%0d flags=%b expected lat=%0d flags=%b",
                 ra, rb, rs, edge_cnt - e0, {gt8, eq8, lt8}, k, r); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_early_stop();
    test_last_digit();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_scan();
    test_single_step();
    test_random8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mag_comparator_seq.md
# mag_comparator_seq

Parametrised, sequential magnitude comparator for WIDTH-bit operands. It scans DIGIT bits per cycle from the MSB downward and stops early at the first differing digit. It supports unsigned and two's-complement comparison and uses a start/busy/done handshake. Datapath blocks use it where a wide compare may take several cycles in exchange for a small, fixed per-cycle comparator cell.

## Interface
- WIDTH, 8, operand width in bits; WIDTH ≥ 2.
- DIGIT, 2, bits compared per cycle; must divide WIDTH; N = WIDTH/DIGIT scan steps.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request a compare; accepted only when busy=0.
- a  in  WIDTH  operand A; sampled on accept.
- b  in  WIDTH  operand B; sampled on accept.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; sampled on accept.
- busy  out  1  high in SCAN and DONE.
- done  out  1  one-cycle pulse; result is valid from this cycle onward.
- a_lt_b  out  1  result flag: A < B.
- a_eq_b  out  1  result flag: A = B.
- a_gt_b  out  1  result flag: A > B.

## Operation
- The FSM has three states: IDLE, SCAN, DONE.
- **IDLE**
  - On an edge with start=1, the block captures a, b and signed_mode into internal registers.
  - It clears all three result flags, sets the digit index to N-1 and goes to SCAN.
- **Signed mode**
  - The captured MSB of both operands is inverted.
  - The compare then proceeds as unsigned. This is exact for two's complement.
- **SCAN**
  - Each cycle, the digit cell compares the digit at the current index of both operand registers.
  - On the edge:
    - If the digits differ: the block writes a_lt_b or a_gt_b and goes to DONE.
    - Else if index = 0: the block writes a_eq_b=1 and goes to DONE.
    - Otherwise the index decrements.
- **DONE**
  - done=1 for exactly one cycle, then the FSM returns to IDLE.
- Result flags hold their value until the next accepted start or reset.
- After done, exactly one result flag is set.
- A start while busy=1 is ignored; it is neither queued nor latched.
- A start in the DONE cycle is also ignored.
- Input changes on a/b/signed_mode after acceptance have no effect.

## Timing
- **Reset values:** state IDLE, busy=0, done=0, a_lt_b=a_eq_b=a_gt_b=0, index=N-1, operand registers 0.
- **Reset mid-operation:** the block aborts immediately (asynchronous) with the values above, and no done is produced.
- **Cycle numbering:** the start edge is E0. Let k be the 1-based position of the first differing digit counted from the MSB, or N if the operands are equal.
  - busy rises after E0.
  - The decision is taken at edge Ek.
  - done is high in the cycle after Ek and falls after E(k+1); busy falls with it.
- **Latency:** best case 2 cycles from accept to done (k=1), worst case N+1.
- **Back-to-back:** start is accepted again on the first edge with busy=0, giving a minimum issue interval of k+2 edges.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- DIGIT=WIDTH is legal: single-step scan, done is always 2 cycles after accept.

## Structure
- **Shared package mag_cmp_pkg:**
  - the state enum (IDLE, SCAN, DONE);
  - the result encoding constants (LT, EQ, GT as a 3-bit one-hot);
  - the elaboration-time parameter check "WIDTH % DIGIT == 0".
- **Sub-module mag_cmp_digit:**
  - parametrised by DIGIT;
  - purely combinational: inputs x, y of DIGIT bits; outputs lt, eq, gt, exactly one high.
  - The top level instantiates exactly one of these and muxes the current digit into it.
- **Digit index:** width is clog2(N), minimum 1.

## Test plan
- **Equal operands:** WIDTH=8, DIGIT=2, unsigned, a=0xA5, b=0xA5, start at E0 -> busy high for 5 cycles, done after E4, a_eq_b=1, others 0.
- **Early stop on MSB digit:** a=0x80, b=0x7F -> unsigned: a_gt_b=1, done after E1. Same operands with signed_mode=1 -> a_lt_b=1, done after E1.
- **Difference in last digit:** a=0x12, b=0x13 unsigned -> a_lt_b=1, done after E4. Signed a=0xFF (-1), b=0xFE (-2) -> a_gt_b=1, done after E4.
- **Start while busy:** start a=0x00, b=0x01; pulse start with a=0xFF, b=0x00 two cycles later -> second request ignored, result a_lt_b=1. Flags hold until the next accepted start clears them.
- **Reset mid-scan:** assert rst_n=0 in SCAN (index 2) -> all outputs 0 immediately, no done. A fresh start after release completes normally.
- **Single-step config:** WIDTH=16, DIGIT=16, a=0x8000, b=0x0001, signed -> a_lt_b=1, done after E1. Compare against a behavioural model with 1000 random operand pairs in both modes.
